// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared constants for the unified memory port arbiter.
//   - Bus widths for address, data and byte enables.
//   - FSM state encoding (IDLE, BUSY, RESP) as fixed constants.
//   - Grant encoding, also used as the bit index into the one-hot grant vector.
package mem_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  localparam logic [BE_W-1:0] BE_FULL = 4'hF;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t BUSY = 2'd1;
  localparam state_t RESP = 2'd2;

  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_D  = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way round-robin picker.
// Ports:
//   req_if   - fetch requester is asking
//   req_d    - data requester is asking
//   last_gnt - who won the previous grant (GNT_IF / GNT_D)
//   gnt      - one-hot grant, indexed by GNT_IF / GNT_D
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       req_if,
  input  logic       req_d,
  input  logic       last_gnt,
  output logic [1:0] gnt
);

  logic if_wins;

  // On a tie, fetch wins only if data had the previous turn.
  assign if_wins = req_if & (~req_d | (last_gnt == GNT_D));

  always_comb begin
    gnt         = '0;
    gnt[GNT_IF] = if_wins;
    gnt[GNT_D]  = req_d & ~if_wins;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one variable-latency memory port between the
// instruction-fetch and load/store requesters of a single-cycle core.
// One transaction is in flight at a time; a response timeout aborts it and
// raises a sticky bus error.
// Ports:
//   clk, reset                      - clock, synchronous active-high reset
//   if_req/if_addr -> if_gnt        - fetch request and same-cycle grant
//   if_rvalid/if_rdata              - fetch completion pulse and instruction
//   d_req/d_we/d_addr/d_wdata/d_be  - load/store request
//   d_gnt, d_rvalid/d_rdata         - data grant, completion pulse, load data
//   mem_req/we/addr/wdata/be        - memory request, held until ack/timeout
//   mem_ack/mem_rdata               - memory completion and read data
//   stall                           - core must hold while access in progress
//   bus_err                         - sticky timeout flag
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [BE_W-1:0]   d_be,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [BE_W-1:0]   mem_be,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall,
  output logic              bus_err
);

  state_t            state;
  logic              last_gnt;
  logic              owner;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        pick;
  logic              idle_ok;
  logic              timeout_hit;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;

  rr_arb2 u_rr_arb2 (
    .req_if   (if_req),
    .req_d    (d_req),
    .last_gnt (last_gnt),
    .gnt      (pick)
  );

  // Grants are only issued from IDLE and are suppressed while reset is held,
  // so a request during reset is never reported as accepted.
  assign idle_ok     = (state == IDLE) & ~reset;
  assign if_gnt      = idle_ok & pick[GNT_IF];
  assign d_gnt       = idle_ok & pick[GNT_D];
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

  assign if_rvalid = (state == RESP) & (owner == GNT_IF) & ~reset;
  assign d_rvalid  = (state == RESP) & (owner == GNT_D) & ~reset;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign stall     = (state != IDLE) | if_req | d_req;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_gnt   <= GNT_D;
      owner      <= GNT_IF;
      cnt        <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      bus_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (if_gnt | d_gnt) begin
            state   <= BUSY;
            cnt     <= '0;
            mem_req <= 1'b1;
            if (if_gnt) begin
              owner     <= GNT_IF;
              last_gnt  <= GNT_IF;
              mem_we    <= 1'b0;
              mem_addr  <= if_addr;
              mem_wdata <= '0;
              mem_be    <= BE_FULL;
            end else begin
              owner     <= GNT_D;
              last_gnt  <= GNT_D;
              mem_we    <= d_we;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              mem_be    <= d_be;
            end
          end
        end
        BUSY: begin
          cnt <= cnt + CNT_W'(1);
          // An ack in the final allowed cycle still wins over the abort.
          if (mem_ack) begin
            state   <= RESP;
            mem_req <= 1'b0;
            if (owner == GNT_IF) begin
              if_rdata_q <= mem_rdata;
            end else begin
              d_rdata_q <= mem_we ? '0 : mem_rdata;
            end
          end else if (timeout_hit) begin
            state   <= RESP;
            mem_req <= 1'b0;
            bus_err <= 1'b1;
            if (owner == GNT_IF) begin
              if_rdata_q <= '0;
            end else begin
              d_rdata_q <= '0;
            end
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: self-checking bench for mem_port_arbiter.
// Table-driven vectors, hand-written multi-cycle sequences, and a randomized
// phase checked against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [3:0]  d_be = '0;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        stall;
  logic        bus_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.TIMEOUT(T), .CNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_be      (d_be),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .stall     (stall),
    .bus_err   (bus_err)
  );

  typedef struct {
    logic        rst;
    logic        if_req;
    logic        d_req;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        e_if_gnt;
    logic        e_d_gnt;
    logic        e_mem_req;
    logic        e_if_rv;
    logic        e_d_rv;
    logic        e_stall;
    logic [31:0] e_if_rdata;
    logic [31:0] e_d_rdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkVec(input logic rst, input logic ir, input logic dr,
                                 input logic ack, input logic [31:0] rd,
                                 input logic eig, input logic edg, input logic emr,
                                 input logic eirv, input logic edrv, input logic est,
                                 input logic [31:0] eird, input logic [31:0] edrd);
    vec_t v;
    v.rst = rst; v.if_req = ir; v.d_req = dr; v.mem_ack = ack; v.mem_rdata = rd;
    v.e_if_gnt = eig; v.e_d_gnt = edg; v.e_mem_req = emr; v.e_if_rv = eirv;
    v.e_d_rv = edrv; v.e_stall = est; v.e_if_rdata = eird; v.e_d_rdata = edrd;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic clearInputs();
    if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0;
    d_wdata = '0; d_be = '0; mem_ack = 0; mem_rdata = '0;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench at posedge+1 of the first cycle after reset.
  task automatic doReset();
    clearInputs();
    reset = 1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 0;
  endtask

  task automatic applyStimulus(input vec_t v);
    if (v.rst) doReset();
    if_req = v.if_req; if_addr = 32'h0000_1000;
    d_req = v.d_req; d_we = 0; d_addr = 32'h0000_2000; d_wdata = '0; d_be = 4'hF;
    mem_ack = v.mem_ack; mem_rdata = v.mem_rdata;
    @(negedge clk);
  endtask

  task automatic doFetch(input logic [31:0] a, input logic [31:0] r);
    if_req = 1; if_addr = a;
    @(negedge clk);
    checkBit("fetch if_gnt", if_gnt, 1'b1);
    nextCycle();
    if_req = 0; mem_ack = 1; mem_rdata = r;
    @(negedge clk);
    checkBit("fetch mem_req", mem_req, 1'b1);
    checkBit("fetch mem_we", mem_we, 1'b0);
    checkOutput("fetch mem_be", {28'b0, mem_be}, 32'hF);
    checkOutput("fetch mem_addr", mem_addr, a);
    nextCycle();
    mem_ack = 0;
    @(negedge clk);
    checkBit("fetch if_rvalid", if_rvalid, 1'b1);
    checkOutput("fetch if_rdata", if_rdata, r);
    nextCycle();
  endtask

  task automatic doLoad(input logic [31:0] a, input logic [31:0] r);
    d_req = 1; d_we = 0; d_addr = a; d_be = 4'hF;
    @(negedge clk);
    checkBit("load d_gnt", d_gnt, 1'b1);
    nextCycle();
    d_req = 0; mem_ack = 1; mem_rdata = r;
    @(negedge clk);
    checkOutput("load mem_addr", mem_addr, a);
    nextCycle();
    mem_ack = 0;
    @(negedge clk);
    checkBit("load d_rvalid", d_rvalid, 1'b1);
    checkOutput("load d_rdata", d_rdata, r);
    nextCycle();
  endtask

  // Transaction-level model: each grant fixes the whole future of its
  // transaction (busy window, ack cycle, response cycle) from the ack delay
  // the bench chose, capped by the timeout.
  task automatic runRandom(input int ncyc);
    int          free_at = 0;
    int          busy_lo = -1;
    int          busy_hi = -2;
    int          ack_at = -1;
    int          rv_at = -1;
    int          k;
    int          lat;
    logic        if_pend = 0;
    logic        d_pend = 0;
    logic        last_d = 1;
    logic        own_d = 0;
    logic        txn_to = 0;
    logic        e_bus_err = 0;
    logic        e_if_gnt;
    logic        e_d_gnt;
    logic        in_busy;
    logic        o_we = 0;
    logic [31:0] o_addr = '0;
    logic [31:0] o_wdata = '0;
    logic [3:0]  o_be = '0;
    logic [31:0] e_if_rdata = '0;
    logic [31:0] e_d_rdata = '0;
    logic [31:0] pend_rdata = '0;
    for (int c = 0; c < ncyc; c++) begin
      if (!if_pend && $urandom_range(0, 2) == 0) begin
        if_pend = 1; if_addr = $urandom;
      end
      if (!d_pend && $urandom_range(0, 2) == 0) begin
        d_pend = 1; d_we = 1'($urandom_range(0, 1)); d_addr = $urandom;
        d_wdata = $urandom; d_be = 4'($urandom);
      end
      if_req = if_pend;
      d_req = d_pend;
      e_if_gnt = 0;
      e_d_gnt = 0;
      if (c >= free_at && (if_pend || d_pend)) begin
        if (if_pend && (!d_pend || last_d)) e_if_gnt = 1;
        else e_d_gnt = 1;
        own_d = e_d_gnt;
        last_d = e_d_gnt;
        o_we = e_d_gnt ? d_we : 1'b0;
        o_addr = e_d_gnt ? d_addr : if_addr;
        o_wdata = d_wdata;
        o_be = e_d_gnt ? d_be : 4'hF;
        k = $urandom_range(1, T + 2);
        lat = (k <= T) ? k : T;
        txn_to = (k > T);
        busy_lo = c + 1;
        busy_hi = c + lat;
        ack_at = txn_to ? -1 : c + k;
        rv_at = c + lat + 1;
        free_at = c + lat + 2;
      end
      in_busy = (c >= busy_lo) && (c <= busy_hi);
      mem_rdata = $urandom;
      if (c == ack_at) begin
        mem_ack = 1;
        pend_rdata = (own_d && o_we) ? 32'h0 : mem_rdata;
      end else if (in_busy) begin
        mem_ack = 0;
      end else begin
        mem_ack = ($urandom_range(0, 3) == 0);
      end
      if (c == rv_at) begin
        if (txn_to) begin
          e_bus_err = 1;
          pend_rdata = '0;
        end
        if (own_d) e_d_rdata = pend_rdata;
        else e_if_rdata = pend_rdata;
      end
      @(negedge clk);
      checkBit("rnd if_gnt", if_gnt, e_if_gnt);
      checkBit("rnd d_gnt", d_gnt, e_d_gnt);
      checkBit("rnd mem_req", mem_req, in_busy);
      if (in_busy) begin
        checkOutput("rnd mem_addr", mem_addr, o_addr);
        checkBit("rnd mem_we", mem_we, o_we);
        checkOutput("rnd mem_be", {28'b0, mem_be}, {28'b0, o_be});
        if (own_d) checkOutput("rnd mem_wdata", mem_wdata, o_wdata);
      end
      checkBit("rnd if_rvalid", if_rvalid, (c == rv_at) && !own_d);
      checkBit("rnd d_rvalid", d_rvalid, (c == rv_at) && own_d);
      checkOutput("rnd if_rdata", if_rdata, e_if_rdata);
      checkOutput("rnd d_rdata", d_rdata, e_d_rdata);
      checkBit("rnd bus_err", bus_err, e_bus_err);
      checkBit("rnd stall", stall, ((c >= busy_lo) && (c <= rv_at)) || if_pend || d_pend);
      if (e_if_gnt) if_pend = 0;
      if (e_d_gnt) d_pend = 0;
      nextCycle();
    end
    clearInputs();
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Single fetch, zero-wait memory.
    vecs.push_back(mkVec(1, 1, 0, 0, 32'h0,        1, 0, 0, 0, 0, 1, 32'h0,        32'h0));
    vecs.push_back(mkVec(0, 0, 0, 1, 32'h00500093, 0, 0, 1, 0, 0, 1, 32'h0,        32'h0));
    vecs.push_back(mkVec(0, 0, 0, 0, 32'h0,        0, 0, 0, 1, 0, 1, 32'h00500093, 32'h0));
    vecs.push_back(mkVec(0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 32'h00500093, 32'h0));
    // Both requesters always asking, ack held high: IF, D, IF, D.
    vecs.push_back(mkVec(1, 1, 1, 1, 32'hFFFFFFFF, 1, 0, 0, 0, 0, 1, 32'h0,    32'h0));
    vecs.push_back(mkVec(0, 1, 1, 1, 32'h00001111, 0, 0, 1, 0, 0, 1, 32'h0,    32'h0));
    vecs.push_back(mkVec(0, 1, 1, 1, 32'hFFFFFFFF, 0, 0, 0, 1, 0, 1, 32'h1111, 32'h0));
    vecs.push_back(mkVec(0, 1, 1, 1, 32'hFFFFFFFF, 0, 1, 0, 0, 0, 1, 32'h1111, 32'h0));
    vecs.push_back(mkVec(0, 1, 1, 1, 32'h00002222, 0, 0, 1, 0, 0, 1, 32'h1111, 32'h0));
    vecs.push_back(mkVec(0, 1, 1, 1, 32'hFFFFFFFF, 0, 0, 0, 0, 1, 1, 32'h1111, 32'h2222));
    vecs.push_back(mkVec(0, 1, 1, 1, 32'hFFFFFFFF, 1, 0, 0, 0, 0, 1, 32'h1111, 32'h2222));
    vecs.push_back(mkVec(0, 1, 1, 1, 32'h00003333, 0, 0, 1, 0, 0, 1, 32'h1111, 32'h2222));
    vecs.push_back(mkVec(0, 1, 1, 1, 32'hFFFFFFFF, 0, 0, 0, 1, 0, 1, 32'h3333, 32'h2222));
    vecs.push_back(mkVec(0, 1, 1, 1, 32'hFFFFFFFF, 0, 1, 0, 0, 0, 1, 32'h3333, 32'h2222));

    $display("[TB] reset state");
    doReset();
    @(negedge clk);
    checkBit("reset mem_req", mem_req, 1'b0);
    checkBit("reset bus_err", bus_err, 1'b0);
    checkOutput("reset mem_addr", mem_addr, 32'h0);
    checkOutput("reset mem_be", {28'b0, mem_be}, 32'h0);
    checkOutput("reset if_rdata", if_rdata, 32'h0);
    checkOutput("reset d_rdata", d_rdata, 32'h0);
    checkBit("reset stall", stall, 1'b0);
    nextCycle();

    $display("[TB] vector table");
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkBit($sformatf("vec%0d if_gnt", i), if_gnt, vecs[i].e_if_gnt);
      checkBit($sformatf("vec%0d d_gnt", i), d_gnt, vecs[i].e_d_gnt);
      checkBit($sformatf("vec%0d mem_req", i), mem_req, vecs[i].e_mem_req);
      checkBit($sformatf("vec%0d if_rvalid", i), if_rvalid, vecs[i].e_if_rv);
      checkBit($sformatf("vec%0d d_rvalid", i), d_rvalid, vecs[i].e_d_rv);
      checkBit($sformatf("vec%0d stall", i), stall, vecs[i].e_stall);
      checkOutput($sformatf("vec%0d if_rdata", i), if_rdata, vecs[i].e_if_rdata);
      checkOutput($sformatf("vec%0d d_rdata", i), d_rdata, vecs[i].e_d_rdata);
      nextCycle();
    end

    $display("[TB] store with ack in last allowed cycle");
    doReset();
    doLoad(32'h80, 32'h12345678);
    d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF; d_be = 4'b0011;
    @(negedge clk);
    checkBit("store d_gnt", d_gnt, 1'b1);
    nextCycle();
    d_req = 0; d_we = 0; d_addr = 32'hFFFFFFFF; d_wdata = '0; d_be = '0;
    for (int i = 1; i <= 4; i++) begin
      mem_ack = (i == 4);
      mem_rdata = 32'hCAFEF00D;
      @(negedge clk);
      checkBit("store mem_req", mem_req, 1'b1);
      checkBit("store mem_we", mem_we, 1'b1);
      checkOutput("store mem_addr", mem_addr, 32'h100);
      checkOutput("store mem_wdata", mem_wdata, 32'hDEADBEEF);
      checkOutput("store mem_be", {28'b0, mem_be}, 32'h3);
      checkBit("store d_rvalid early", d_rvalid, 1'b0);
      nextCycle();
    end
    mem_ack = 0;
    @(negedge clk);
    checkBit("store d_rvalid", d_rvalid, 1'b1);
    checkOutput("store d_rdata", d_rdata, 32'h0);
    checkBit("store mem_req drop", mem_req, 1'b0);
    checkBit("store bus_err", bus_err, 1'b0);
    nextCycle();
    @(negedge clk);
    checkBit("store d_rvalid once", d_rvalid, 1'b0);
    checkBit("store stall idle", stall, 1'b0);
    nextCycle();

    $display("[TB] load timeout");
    doLoad(32'h84, 32'h87654321);
    d_req = 1; d_we = 0; d_addr = 32'h200; d_be = 4'hF;
    @(negedge clk);
    checkBit("timeout d_gnt", d_gnt, 1'b1);
    nextCycle();
    d_req = 0;
    for (int i = 1; i <= T; i++) begin
      @(negedge clk);
      checkBit("timeout mem_req held", mem_req, 1'b1);
      checkBit("timeout bus_err early", bus_err, 1'b0);
      nextCycle();
    end
    @(negedge clk);
    checkBit("timeout mem_req drop", mem_req, 1'b0);
    checkBit("timeout d_rvalid", d_rvalid, 1'b1);
    checkOutput("timeout d_rdata", d_rdata, 32'h0);
    checkBit("timeout bus_err", bus_err, 1'b1);
    nextCycle();
    @(negedge clk);
    checkBit("timeout d_rvalid once", d_rvalid, 1'b0);
    nextCycle();
    doFetch(32'h300, 32'h00A00113);
    @(negedge clk);
    checkBit("bus_err sticky", bus_err, 1'b1);
    nextCycle();

    $display("[TB] reset during fetch");
    doReset();
    if_req = 1; if_addr = 32'h40;
    @(negedge clk);
    checkBit("midrst if_gnt", if_gnt, 1'b1);
    nextCycle();
    if_req = 0;
    @(negedge clk);
    checkBit("midrst mem_req busy", mem_req, 1'b1);
    nextCycle();
    reset = 1;
    nextCycle();
    reset = 0; mem_ack = 1; mem_rdata = 32'h13579BDF;
    @(negedge clk);
    checkBit("midrst mem_req", mem_req, 1'b0);
    checkBit("midrst if_rvalid", if_rvalid, 1'b0);
    checkBit("midrst stall", stall, 1'b0);
    nextCycle();
    mem_ack = 0;
    @(negedge clk);
    checkBit("midrst if_rvalid later", if_rvalid, 1'b0);
    checkOutput("midrst if_rdata", if_rdata, 32'h0);
    nextCycle();
    if_req = 1; d_req = 1;
    @(negedge clk);
    checkBit("midrst tie if_gnt", if_gnt, 1'b1);
    checkBit("midrst tie d_gnt", d_gnt, 1'b0);
    nextCycle();

    $display("[TB] spurious ack in IDLE");
    doReset();
    doFetch(32'h500, 32'hABCD0001);
    doLoad(32'h600, 32'h5555AAAA);
    for (int i = 0; i < 3; i++) begin
      mem_ack = 1; mem_rdata = 32'h0BADF00D;
      @(negedge clk);
      checkBit("spur if_rvalid", if_rvalid, 1'b0);
      checkBit("spur d_rvalid", d_rvalid, 1'b0);
      checkBit("spur mem_req", mem_req, 1'b0);
      checkOutput("spur if_rdata", if_rdata, 32'hABCD0001);
      checkOutput("spur d_rdata", d_rdata, 32'h5555AAAA);
      nextCycle();
    end

    $display("[TB] randomized traffic");
    doReset();
    runRandom(600);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
